mem_access_ctrl: RTL and testbench

Request/response front end that sits directly upstream of the 16K-byte data memory and is the only master driving it. Accepts load/store requests from the core over a valid/ready handshake and sequences the memory's address, write data and write-enable. Word accesses pass straight through; byte accesses are read-modify-write. Responses are returned over a valid/ready channel with an error flag.

---
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store front end for the 16K-byte data memory
// Word accesses go straight through; byte stores are read-modify-write.
module mem_access_ctrl #(
  parameter int ADDR_W        = 14,
  parameter int DATA_W        = 16,
  parameter bit SIGN_EXT_BYTE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_ERR, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              byte_q, byte_d;
  logic              lane_hi_q, lane_hi_d;
  logic [7:0]        wbyte_q, wbyte_d;

  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        rd_byte;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = req_ready_q;
    byte_d      = byte_q;
    lane_hi_d   = lane_hi_q;
    wbyte_d     = wbyte_q;
    // The base word always sits at the odd address; its low byte is at W-1.
    word_addr   = {req_addr[ADDR_W-1:1], 1'b1};
    rd_byte     = lane_hi_q ? mem_rdata[15:8] : mem_rdata[7:0];

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          byte_d      = req_byte;
          lane_hi_d   = req_addr[0];
          wbyte_d     = req_wdata[7:0];
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          if (!req_byte && !req_addr[0]) begin
            state_d = S_ERR;
          end else if (!req_write) begin
            state_d    = S_RD;
            mem_addr_d = word_addr;
          end else if (!req_byte) begin
            state_d     = S_WR;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            mem_we_d    = 1'b1;
          end else begin
            state_d    = S_RMW_RD;
            mem_addr_d = word_addr;
          end
        end
      end
      S_RD: begin
        if (byte_q) begin
          rsp_data_d = {{(DATA_W-8){SIGN_EXT_BYTE & rd_byte[7]}}, rd_byte};
        end else begin
          rsp_data_d = mem_rdata;
        end
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RMW_RD: begin
        mem_wdata_d = lane_hi_q ? {wbyte_q, mem_rdata[7:0]}
                                : {mem_rdata[DATA_W-1:8], wbyte_q};
        mem_we_d    = 1'b1;
        state_d     = S_RMW_WR;
      end
      S_RMW_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_ERR: begin
        rsp_err_d   = 1'b1;
        rsp_data_d  = '0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        // Ready returns one cycle after the handshake, so no same-cycle accept.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      byte_q      <= 1'b0;
      lane_hi_q   <= 1'b0;
      wbyte_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      byte_q      <= byte_d;
      lane_hi_q   <= lane_hi_d;
      wbyte_q     <= wbyte_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed bench for mem_access_ctrl
// Two instances (zero- and sign-extending byte loads) share one stimulus stream.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [13:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready0, rsp_valid0, rsp_err0, mem_we0;
  logic [15:0] rsp_data0, mem_wdata0, mem_rdata0;
  logic [13:0] mem_addr0, am1_0;
  logic        req_ready1, rsp_valid1, rsp_err1, mem_we1;
  logic [15:0] rsp_data1, mem_wdata1, mem_rdata1;
  logic [13:0] mem_addr1, am1_1;

  logic [7:0] mem0 [0:16383];
  logic [7:0] mem1 [0:16383];

  int vec  = 0;
  int miss = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(14), .DATA_W(16), .SIGN_EXT_BYTE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data0), .rsp_err(rsp_err0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_rdata(mem_rdata0)
  );

  mem_access_ctrl #(.ADDR_W(14), .DATA_W(16), .SIGN_EXT_BYTE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data1), .rsp_err(rsp_err1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1)
  );

  assign am1_0 = mem_addr0 - 14'd1;
  assign am1_1 = mem_addr1 - 14'd1;
  assign mem_rdata0 = {mem0[mem_addr0], mem0[am1_0]};
  assign mem_rdata1 = {mem1[mem_addr1], mem1[am1_1]};

  always @(posedge clk) begin
    if (mem_we0) begin
      mem0[mem_addr0] <= mem_wdata0[15:8];
      mem0[am1_0]     <= mem_wdata0[7:0];
      we_cnt          <= we_cnt + 1;
    end
    if (mem_we1) begin
      mem1[mem_addr1] <= mem_wdata1[15:8];
      mem1[am1_1]     <= mem_wdata1[7:0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic issue(input logic w, input logic b, input logic [13:0] a,
                       input logic [15:0] wd, output int lat,
                       output logic [15:0] d0, output logic [15:0] d1,
                       output logic e);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a;
    req_wdata = wd; rsp_ready = 1'b1;
    k = 0;
    while (!req_ready0 && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid0) break;
    end
    lat = k + 1;
    if (k == 20) begin
      vec++; miss++;
      $display("FAIL issue_timeout addr=%h no rsp_valid within 20 cycles", a);
    end
    d0 = rsp_data0; d1 = rsp_data1; e = rsp_err0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({req_ready0, rsp_valid0, rsp_err0, mem_we0} !== 4'b1000) begin
      miss++;
      $display("FAIL reset_ctrl got rdy/vld/err/we=%b want 1000",
               {req_ready0, rsp_valid0, rsp_err0, mem_we0});
    end
    vec++;
    if ({mem_addr0, mem_wdata0, rsp_data0} !== 46'd0) begin
      miss++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0",
               mem_addr0, mem_wdata0, rsp_data0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    int lat, w0;
    logic [15:0] d0, d1;
    logic e;
    w0 = we_cnt;
    issue(1'b1, 1'b0, 14'h0011, 16'hBEEF, lat, d0, d1, e);
    vec++;
    if (lat !== 2 || e !== 1'b0 || d0 !== 16'h0000) begin
      miss++;
      $display("FAIL word_store lat=%0d err=%b data=%h want 2/0/0000", lat, e, d0);
    end
    vec++;
    if (we_cnt - w0 !== 1 || mem0[14'h0011] !== 8'hBE || mem0[14'h0010] !== 8'hEF) begin
      miss++;
      $display("FAIL word_store_mem we=%0d hi=%h lo=%h want 1/BE/EF",
               we_cnt - w0, mem0[14'h0011], mem0[14'h0010]);
    end
    issue(1'b0, 1'b0, 14'h0011, 16'h0000, lat, d0, d1, e);
    vec++;
    if (d0 !== 16'hBEEF || e !== 1'b0 || lat !== 2) begin
      miss++;
      $display("FAIL word_load data=%h err=%b lat=%0d want BEEF/0/2", d0, e, lat);
    end
  endtask

  task automatic test_byte_store();
    int lat, w0;
    logic [15:0] d0, d1;
    logic e;
    issue(1'b1, 1'b0, 14'h0021, 16'h1234, lat, d0, d1, e);
    w0 = we_cnt;
    issue(1'b1, 1'b1, 14'h0020, 16'h99AB, lat, d0, d1, e);
    vec++;
    if (lat !== 3 || e !== 1'b0 || we_cnt - w0 !== 1) begin
      miss++;
      $display("FAIL byte_store_lo lat=%0d err=%b we=%0d want 3/0/1", lat, e, we_cnt - w0);
    end
    issue(1'b0, 1'b0, 14'h0021, 16'h0000, lat, d0, d1, e);
    vec++;
    if (d0 !== 16'h12AB) begin
      miss++;
      $display("FAIL byte_store_lo_rb got %h want 12AB", d0);
    end
    w0 = we_cnt;
    issue(1'b1, 1'b1, 14'h0021, 16'h77CD, lat, d0, d1, e);
    vec++;
    if (lat !== 3 || we_cnt - w0 !== 1) begin
      miss++;
      $display("FAIL byte_store_hi lat=%0d we=%0d want 3/1", lat, we_cnt - w0);
    end
    issue(1'b0, 1'b0, 14'h0021, 16'h0000, lat, d0, d1, e);
    vec++;
    if (d0 !== 16'hCDAB) begin
      miss++;
      $display("FAIL byte_store_hi_rb got %h want CDAB", d0);
    end
  endtask

  task automatic test_byte_load();
    int lat;
    logic [15:0] d0, d1;
    logic e;
    issue(1'b1, 1'b0, 14'h0031, 16'h80FF, lat, d0, d1, e);
    issue(1'b0, 1'b1, 14'h0031, 16'h0000, lat, d0, d1, e);
    vec++;
    if (d0 !== 16'h0080 || d1 !== 16'hFF80 || lat !== 2) begin
      miss++;
      $display("FAIL byte_load_hi zext=%h sext=%h lat=%0d want 0080/FF80/2", d0, d1, lat);
    end
    issue(1'b0, 1'b1, 14'h0030, 16'h0000, lat, d0, d1, e);
    vec++;
    if (d0 !== 16'h00FF || d1 !== 16'hFFFF) begin
      miss++;
      $display("FAIL byte_load_lo zext=%h sext=%h want 00FF/FFFF", d0, d1);
    end
  endtask

  task automatic test_misaligned();
    int lat, w0;
    logic [15:0] d0, d1;
    logic e;
    logic [7:0] b40, b3f, b41;
    b40 = mem0[14'h0040]; b3f = mem0[14'h003F]; b41 = mem0[14'h0041];
    w0 = we_cnt;
    issue(1'b1, 1'b0, 14'h0040, 16'h5555, lat, d0, d1, e);
    vec++;
    if (e !== 1'b1 || d0 !== 16'h0000 || lat !== 2) begin
      miss++;
      $display("FAIL misaligned_rsp err=%b data=%h lat=%0d want 1/0000/2", e, d0, lat);
    end
    vec++;
    if (we_cnt != w0 || mem0[14'h0040] !== b40 || mem0[14'h003F] !== b3f ||
        mem0[14'h0041] !== b41) begin
      miss++;
      $display("FAIL misaligned_mem we=%0d want 0 or memory modified", we_cnt - w0);
    end
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 14'h0011; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_addr = 14'h0021;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid0) break;
    end
    for (int i = 0; i < 5; i++) begin
      vec++;
      if (rsp_valid0 !== 1'b1 || rsp_data0 !== 16'hBEEF || rsp_err0 !== 1'b0 ||
          req_ready0 !== 1'b0) begin
        miss++;
        $display("FAIL backpressure_hold cyc=%0d vld=%b data=%h err=%b rdy=%b want 1/BEEF/0/0",
                 i, rsp_valid0, rsp_data0, rsp_err0, req_ready0);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      miss++;
      $display("FAIL backpressure_release vld=%b rdy=%b want 0/1", rsp_valid0, req_ready0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid0) break;
    end
    vec++;
    if (k !== 1 || rsp_data0 !== 16'hCDAB) begin
      miss++;
      $display("FAIL backpressure_next lat=%0d data=%h want 2/CDAB", k + 1, rsp_data0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, w0;
    logic [15:0] d0, d1;
    logic e;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
    req_addr = 14'h0021; req_wdata = 16'h0011; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    vec++;
    if (req_ready0 !== 1'b1 || mem_we0 !== 1'b0 || rsp_valid0 !== 1'b0 ||
        mem_addr0 !== 14'h0000) begin
      miss++;
      $display("FAIL reset_mid_now rdy=%b we=%b vld=%b addr=%h want 1/0/0/0000",
               req_ready0, mem_we0, rsp_valid0, mem_addr0);
    end
    repeat (2) @(negedge clk);
    vec++;
    if (rsp_valid0 !== 1'b0 || we_cnt != w0) begin
      miss++;
      $display("FAIL reset_mid_hold vld=%b we=%0d want 0/0", rsp_valid0, we_cnt - w0);
    end
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 14'h0021, 16'h0000, lat, d0, d1, e);
    vec++;
    if (d0 !== 16'hCDAB || e !== 1'b0 || lat !== 2) begin
      miss++;
      $display("FAIL reset_mid_after data=%h err=%b lat=%0d want CDAB/0/2", d0, e, lat);
    end
    issue(1'b1, 1'b1, 14'h0020, 16'h005A, lat, d0, d1, e);
    issue(1'b0, 1'b0, 14'h0021, 16'h0000, lat, d0, d1, e);
    vec++;
    if (d0 !== 16'hCD5A) begin
      miss++;
      $display("FAIL reset_mid_rmw got %h want CD5A", d0);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_store();
    test_byte_load();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
